// File: rtl/stream_sub_min_if.sv
// Operand/result stream bundle for stream_sub_min.
// Master drives operands and out_ready; slave returns in_ready and results.
// Widths follow the WIDTH/CNT_W parameters of the instance.
interface stream_sub_min_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_run_min;
  logic [CNT_W-1:0] out_count;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_diff, out_min, out_run_min, out_count, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_diff, out_min, out_run_min, out_count, out_last
  );
endinterface

// File: rtl/stream_sub_min.sv
// Streaming a-b, signed min, and per-frame running min / saturating beat count.
// Latency 2 cycles (S1 operands, S2 output regs), throughput 1 beat/cycle.
// Fully back-pressured: in_ready = !s1_valid || !s2_valid || out_ready (comb).
module stream_sub_min #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  stream_sub_min_if.slave  bus
);

  typedef enum logic {ST_FIRST, ST_IN_FRAME} frame_st_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Stage 1 registers
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_diff_q;
  logic [WIDTH-1:0] s1_min_q;
  logic             s1_last_q;

  // Stage 2 (output) registers
  logic             s2_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q;

  frame_st_e        state_q, state_d;

  logic             adv1, adv2, in_fire, mv12;
  logic [WIDTH-1:0] in_min;

  // Stall chain: S2 frees when empty or draining; S1 frees when empty or S2 frees.
  assign adv2    = !s2_valid_q || bus.out_ready;
  assign adv1    = !s1_valid_q || adv2;
  assign in_fire = bus.in_valid && adv1;
  assign mv12    = s1_valid_q && adv2;

  // Ties resolve to a.
  assign in_min = ($signed(bus.in_b) < $signed(bus.in_a)) ? bus.in_b : bus.in_a;

  // Stage 1: capture difference and min of the accepted pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_min_q   <= '0;
      s1_last_q  <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid;
      if (in_fire) begin
        s1_diff_q <= bus.in_a - bus.in_b;
        s1_min_q  <= in_min;
        s1_last_q <= bus.in_last;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next-state plus running min / saturating count for the beat moving S1->S2.
  always_comb begin
    state_d   = state_q;
    run_min_d = run_min_q;
    count_d   = count_q;
    if (mv12) begin
      if (state_q == ST_FIRST) begin
        run_min_d = s1_min_q;
        count_d   = CNT_ONE;
      end else begin
        run_min_d = ($signed(s1_min_q) < $signed(run_min_q)) ? s1_min_q : run_min_q;
        count_d   = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
      end
      state_d = s1_last_q ? ST_FIRST : ST_IN_FRAME;
    end
  end

  // Stage 2: output registers, held while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      min_q      <= '0;
      run_min_q  <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (mv12) begin
        diff_q    <= s1_diff_q;
        min_q     <= s1_min_q;
        run_min_q <= run_min_d;
        count_q   <= count_d;
        last_q    <= s1_last_q;
      end
    end
  end

  assign bus.in_ready    = adv1;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_diff    = diff_q;
  assign bus.out_min     = min_q;
  assign bus.out_run_min = run_min_q;
  assign bus.out_count   = count_q;
  assign bus.out_last    = last_q;

endmodule

// File: tb/tb_stream_sub_min.sv
// Bench for stream_sub_min: two instances (CNT_W=16 and CNT_W=2) driven identically.
// Expected results come from a per-beat arithmetic model held in queues.
// Outputs are sampled on the falling edge, inputs driven 1ns after the rising edge.
module tb_stream_sub_min;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_sub_min_if #(.WIDTH(8), .CNT_W(16)) if0 ();
  stream_sub_min_if #(.WIDTH(8), .CNT_W(2))  if1 ();

  stream_sub_min #(.WIDTH(8), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  stream_sub_min #(.WIDTH(8), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic [7:0] diff;
    logic [7:0] mn;
    logic [7:0] rm;
    int         cnt;
    logic       last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   fpos [2];
  int   rmin [2];

  int   vectors     = 0;
  int   miscompares = 0;
  logic held0       = 1'b0;
  logic [40:0] snap0;
  logic acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: difference mod 256, signed min, running min and 1-based beat index per frame.
  task automatic model_push(input int d, input logic [7:0] a, input logic [7:0] b, input logic l);
    int ia, ib, mn;
    exp_t e;
    ia = $signed(a);
    ib = $signed(b);
    mn = (ib < ia) ? ib : ia;
    if (fpos[d] == 0) rmin[d] = mn;
    else if (mn < rmin[d]) rmin[d] = mn;
    e.diff = 8'(ia - ib);
    e.mn   = 8'(mn);
    e.rm   = 8'(rmin[d]);
    e.cnt  = fpos[d] + 1;
    e.last = l;
    fpos[d] = l ? 0 : fpos[d] + 1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic check_out(input int d, input logic ov, input logic [7:0] df, input logic [7:0] mn,
                           input logic [7:0] rm, input logic [15:0] cnt, input logic lst);
    exp_t e;
    int   cap;
    string p;
    p   = (d == 0) ? "d0" : "d1";
    cap = (d == 0) ? 65535 : 3;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk({p, "_spurious_out"}, {31'd0, ov}, 32'd0);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk({p, "_diff"},    {24'd0, df},  {24'd0, e.diff});
      chk({p, "_min"},     {24'd0, mn},  {24'd0, e.mn});
      chk({p, "_run_min"}, {24'd0, rm},  {24'd0, e.rm});
      chk({p, "_count"},   {16'd0, cnt}, (e.cnt > cap) ? cap : e.cnt);
      chk({p, "_last"},    {31'd0, lst}, {31'd0, e.last});
    end
  endtask

  // One clock cycle: drive, then score outputs/acceptances at the falling edge.
  task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic l, input logic ordy, output logic accepted);
    @(posedge clk);
    #1;
    rst = r;
    if0.in_valid = v; if0.in_a = a; if0.in_b = b; if0.in_last = l; if0.out_ready = ordy;
    if1.in_valid = v; if1.in_a = a; if1.in_b = b; if1.in_last = l; if1.out_ready = ordy;
    @(negedge clk);
    accepted = 1'b0;
    if (r) begin
      q0.delete();
      q1.delete();
      fpos[0] = 0; fpos[1] = 0;
      held0 = 1'b0;
    end else begin
      if (held0) begin
        chk("hold_valid", {31'd0, if0.out_valid}, 32'd1);
        chk("hold_data", {if0.out_diff, if0.out_min, if0.out_run_min} ^ snap0[40:17], snap0[40:17] ^ snap0[40:17]);
        chk("hold_cnt_last", {if0.out_count, if0.out_last}, snap0[16:0]);
      end
      if (if0.out_valid && if0.out_ready)
        check_out(0, if0.out_valid, if0.out_diff, if0.out_min, if0.out_run_min, if0.out_count, if0.out_last);
      if (if1.out_valid && if1.out_ready)
        check_out(1, if1.out_valid, if1.out_diff, if1.out_min, if1.out_run_min, {14'd0, if1.out_count}, if1.out_last);
      if (if0.in_valid && if0.in_ready) model_push(0, a, b, l);
      if (if1.in_valid && if1.in_ready) model_push(1, a, b, l);
      accepted = if0.in_valid && if0.in_ready;
      held0 = if0.out_valid && !if0.out_ready;
      snap0 = {if0.out_diff, if0.out_min, if0.out_run_min, if0.out_count, if0.out_last};
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) step(1'b0, 1'b1, a, b, l, 1'b1, ok);
    chk("send_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic dummy;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, dummy);
  endtask

  // Single beat then two idle cycles: result must be on the output exactly then.
  task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic [7:0] em);
    send(a, b, 1'b1);
    idle(1);
    chk("lat_early", {31'd0, if0.out_valid}, 32'd0);
    idle(1);
    chk("lat_valid", {31'd0, if0.out_valid}, 32'd1);
    chk("single_diff", {24'd0, if0.out_diff}, {24'd0, ed});
    chk("single_min",  {24'd0, if0.out_min},  {24'd0, em});
    chk("single_rmin", {24'd0, if0.out_run_min}, {24'd0, em});
    chk("single_cnt",  {16'd0, if0.out_count}, 32'd1);
    chk("single_last", {31'd0, if0.out_last}, 32'd1);
  endtask

  initial begin
    int idx, k;
    logic [7:0] sa [6];
    logic [7:0] sb [6];
    fpos[0] = 0; fpos[1] = 0; rmin[0] = 0; rmin[1] = 0;
    if0.in_valid = 0; if0.in_a = 0; if0.in_b = 0; if0.in_last = 0; if0.out_ready = 0;
    if1.in_valid = 0; if1.in_a = 0; if1.in_b = 0; if1.in_last = 0; if1.out_ready = 0;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    chk("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, if0.in_ready},  32'd1);
    chk("rst_diff",      {24'd0, if0.out_diff},  32'd0);
    chk("rst_run_min",   {24'd0, if0.out_run_min}, 32'd0);
    chk("rst_count",     {16'd0, if0.out_count}, 32'd0);

    // Basic single-beat frames and wrap cases
    single(8'd5, 8'd3, 8'h02, 8'h03);
    single(8'h80, 8'h7F, 8'h01, 8'h80);
    single(8'h7F, 8'h80, 8'hFF, 8'h80);

    // Frame of mins 10, -3, 7 then a single beat with min 20
    send(8'd10, 8'd12, 1'b0);
    send(8'hFD, 8'd5,  1'b0);
    send(8'd9,  8'd7,  1'b1);
    send(8'd20, 8'd30, 1'b1);
    idle(4);

    // Back-to-back 6 beats with a 3-cycle sink stall
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    idx = 0;
    k = 0;
    while ((idx < 6 || k < 12) && k < 60) begin
      step(1'b0, (idx < 6), sa[idx % 6], sb[idx % 6], (idx == 5), !(k >= 2 && k < 5), acc);
      if (acc) idx++;
      if (k == 4) chk("full_in_ready", {31'd0, if0.in_ready}, 32'd0);
      k++;
    end
    chk("stall_drain", q0.size(), 32'd0);

    // Reset with two beats in flight mid-frame
    send(8'd1, 8'd2, 1'b0);
    step(1'b0, 1'b1, 8'd3, 8'd4, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 8'd5, 8'd6, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc);
    chk("midrst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, if0.in_ready},  32'd1);
    send(8'hF9, 8'd2, 1'b0);
    idle(2);
    chk("midrst_count",   {16'd0, if0.out_count},   32'd1);
    chk("midrst_run_min", {24'd0, if0.out_run_min}, 32'hF9);
    send(8'd40, 8'd50, 1'b1);
    idle(3);

    // 5-beat frame: CNT_W=2 instance saturates at 3, then a new frame restarts at 1
    for (int i = 0; i < 5; i++) send(8'(i * 7), 8'(30 - i), (i == 4));
    send(8'd9, 8'd9, 1'b1);
    idle(3);
    chk("sat_restart_cnt", {30'd0, if1.out_count}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), acc);
    idle(10);
    chk("final_drain_d0", q0.size(), 32'd0);
    chk("final_drain_d1", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
